// File: rtl/lbm_pkg.sv
// Shared constants and types for the D2Q9 lid-driven-cavity sweep scheduler:
// lattice defaults, direction encoding, velocity vectors and FSM state codes.
package lbm_pkg;

   localparam int LBM_NX      = 16;
   localparam int LBM_NY      = 16;
   localparam int LBM_ADDR_W2 = $clog2(LBM_NX * LBM_NY) + 1;
   localparam int NUM_DIRS    = 9;

   localparam logic [LBM_ADDR_W2-1:0] INVALID_ADDR = '1;

   typedef enum logic [3:0] {
      DIR_REST = 4'd0,
      DIR_E    = 4'd1,
      DIR_N    = 4'd2,
      DIR_W    = 4'd3,
      DIR_S    = 4'd4,
      DIR_NE   = 4'd5,
      DIR_NW   = 4'd6,
      DIR_SW   = 4'd7,
      DIR_SE   = 4'd8
   } dir_t;

   // Lattice velocity components indexed by dir_t (2'b11 == -1).
   localparam logic signed [1:0] CX [NUM_DIRS] =
      '{2'b00, 2'b01, 2'b00, 2'b11, 2'b00, 2'b01, 2'b11, 2'b11, 2'b01};
   localparam logic signed [1:0] CY [NUM_DIRS] =
      '{2'b00, 2'b00, 2'b01, 2'b00, 2'b11, 2'b01, 2'b01, 2'b11, 2'b11};

   typedef logic [2:0] sched_state_t;
   localparam sched_state_t ST_IDLE     = 3'd0;
   localparam sched_state_t ST_ISSUE    = 3'd1;
   localparam sched_state_t ST_WAIT     = 3'd2;
   localparam sched_state_t ST_STEP_END = 3'd3;
   localparam sched_state_t ST_FINISH   = 3'd4;

endpackage

// File: rtl/lbm_neighbor_addr.sv
// Combinational stream-target address for one lattice direction; returns
// all-ones when the neighbour lies outside the grid.
module lbm_neighbor_addr
   import lbm_pkg::*;
#(
   parameter int NX             = LBM_NX,
   parameter int NY             = LBM_NY,
   parameter int ADDRESS_WIDTH2 = $clog2(NX * NY) + 1,
   parameter int X_W            = $clog2(NX),
   parameter int Y_W            = $clog2(NY)
) (
   input  logic [X_W-1:0]            x,
   input  logic [Y_W-1:0]            y,
   input  dir_t                      dir,
   output logic [ADDRESS_WIDTH2-1:0] addr
);

   localparam logic [X_W+1:0] NX_W = (X_W + 2)'(NX);
   localparam logic [Y_W+1:0] NY_W = (Y_W + 2)'(NY);

   logic signed [1:0] cx;
   logic signed [1:0] cy;
   logic [X_W+1:0]    nx;
   logic [Y_W+1:0]    ny;
   logic              off_grid;

   // A step of -1 from 0 wraps to a value with the top bit set, so the top
   // bit doubles as the "below zero" flag.
   always_comb begin
      cx       = CX[dir];
      cy       = CY[dir];
      nx       = {2'b00, x} + {{X_W{cx[1]}}, cx};
      ny       = {2'b00, y} + {{Y_W{cy[1]}}, cy};
      off_grid = nx[X_W+1] | (nx >= NX_W) | ny[Y_W+1] | (ny >= NY_W);
      if (off_grid) begin
         addr = '1;
      end else begin
         addr = ADDRESS_WIDTH2'(ny) * ADDRESS_WIDTH2'(NX) + ADDRESS_WIDTH2'(nx);
      end
   end

endmodule

// File: rtl/lbm_sweep_scheduler.sv
// Row-major lattice sweep sequencer: issues one collide/stream pass per node
// via a start/done handshake, repeated for a programmed number of time steps.
module lbm_sweep_scheduler
   import lbm_pkg::*;
#(
   parameter int NX             = LBM_NX,
   parameter int NY             = LBM_NY,
   parameter int GRID_DIM       = NX * NY,
   parameter int ADDRESS_WIDTH  = $clog2(GRID_DIM),
   parameter int ADDRESS_WIDTH2 = $clog2(GRID_DIM) + 1,
   parameter int STEP_WIDTH     = 16
) (
   input  logic                      Clk,
   input  logic                      Reset,
   input  logic                      start,
   input  logic                      abort,
   input  logic [STEP_WIDTH-1:0]     num_steps,
   input  logic                      node_done,
   output logic                      busy,
   output logic                      node_start,
   output logic [ADDRESS_WIDTH-1:0]  node_addr,
   output logic                      LID,
   output logic                      BOTTOM_WALL,
   output logic                      LEFT_WALL,
   output logic                      RIGHT_WALL,
   output logic [ADDRESS_WIDTH2-1:0] stream_addr0,
   output logic [ADDRESS_WIDTH2-1:0] stream_addr1,
   output logic [ADDRESS_WIDTH2-1:0] stream_addr2,
   output logic [ADDRESS_WIDTH2-1:0] stream_addr3,
   output logic [ADDRESS_WIDTH2-1:0] stream_addr4,
   output logic [ADDRESS_WIDTH2-1:0] stream_addr5,
   output logic [ADDRESS_WIDTH2-1:0] stream_addr6,
   output logic [ADDRESS_WIDTH2-1:0] stream_addr7,
   output logic [ADDRESS_WIDTH2-1:0] stream_addr8,
   output logic                      buf_sel,
   output logic [STEP_WIDTH-1:0]     step_count,
   output logic                      sweep_done,
   output logic                      all_done
);

   localparam int X_W = $clog2(NX);
   localparam int Y_W = $clog2(NY);
   localparam logic [X_W-1:0]           X_MAX     = X_W'(NX - 1);
   localparam logic [Y_W-1:0]           Y_MAX     = Y_W'(NY - 1);
   localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(GRID_DIM - 1);

   sched_state_t          state_q, state_d;
   logic [X_W-1:0]        x_q, x_d;
   logic [Y_W-1:0]        y_q, y_d;
   logic [STEP_WIDTH-1:0] step_count_q, step_count_d;
   logic [STEP_WIDTH-1:0] num_steps_q, num_steps_d;
   logic [STEP_WIDTH-1:0] step_inc;
   logic                  buf_sel_q, buf_sel_d;
   logic                  busy_q, busy_d;
   logic                  zero_done_q, zero_done_d;
   logic                  last_node;
   logic                  row_interior;

   logic [ADDRESS_WIDTH2-1:0] stream_w [NUM_DIRS];

   assign node_addr    = ADDRESS_WIDTH'(y_q) * ADDRESS_WIDTH'(NX) + ADDRESS_WIDTH'(x_q);
   assign last_node    = (node_addr == LAST_ADDR);
   assign step_inc     = step_count_q + STEP_WIDTH'(1);
   assign row_interior = (y_q != '0) && (y_q != Y_MAX);

   always_comb begin
      state_d      = state_q;
      x_d          = x_q;
      y_d          = y_q;
      step_count_d = step_count_q;
      num_steps_d  = num_steps_q;
      buf_sel_d    = buf_sel_q;
      busy_d       = busy_q;
      zero_done_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (num_steps != '0) begin
                  num_steps_d  = num_steps;
                  x_d          = '0;
                  y_d          = '0;
                  step_count_d = '0;
                  buf_sel_d    = 1'b0;
                  busy_d       = 1'b1;
                  state_d      = ST_ISSUE;
               end else begin
                  zero_done_d = 1'b1;
               end
            end
         end
         // node_done during ISSUE is deliberately not looked at.
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT: begin
            if (node_done) begin
               if (last_node) begin
                  state_d = ST_STEP_END;
               end else begin
                  if (x_q == X_MAX) begin
                     x_d = '0;
                     y_d = y_q + Y_W'(1);
                  end else begin
                     x_d = x_q + X_W'(1);
                  end
                  state_d = ST_ISSUE;
               end
            end
         end
         ST_STEP_END: begin
            step_count_d = step_inc;
            buf_sel_d    = ~buf_sel_q;
            if (step_inc == num_steps_q) begin
               busy_d  = 1'b0;
               state_d = ST_FINISH;
            end else begin
               x_d     = '0;
               y_d     = '0;
               state_d = ST_ISSUE;
            end
         end
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase

      // Abort wins over everything, including a coincident node_done.
      if (abort && (state_q != ST_IDLE)) begin
         state_d      = ST_IDLE;
         busy_d       = 1'b0;
         x_d          = x_q;
         y_d          = y_q;
         step_count_d = step_count_q;
         buf_sel_d    = buf_sel_q;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_q      <= ST_IDLE;
         x_q          <= '0;
         y_q          <= '0;
         step_count_q <= '0;
         buf_sel_q    <= 1'b0;
         busy_q       <= 1'b0;
         zero_done_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         x_q          <= x_d;
         y_q          <= y_d;
         step_count_q <= step_count_d;
         buf_sel_q    <= buf_sel_d;
         busy_q       <= busy_d;
         zero_done_q  <= zero_done_d;
      end
   end

   always_ff @(posedge Clk) begin
      num_steps_q <= num_steps_d;
   end

   for (genvar d = 0; d < NUM_DIRS; d++) begin : g_nb
      lbm_neighbor_addr #(
         .NX             (NX),
         .NY             (NY),
         .ADDRESS_WIDTH2 (ADDRESS_WIDTH2),
         .X_W            (X_W),
         .Y_W            (Y_W)
      ) u_nb (
         .x    (x_q),
         .y    (y_q),
         .dir  (dir_t'(d)),
         .addr (stream_w[d])
      );
   end

   assign stream_addr0 = stream_w[0];
   assign stream_addr1 = stream_w[1];
   assign stream_addr2 = stream_w[2];
   assign stream_addr3 = stream_w[3];
   assign stream_addr4 = stream_w[4];
   assign stream_addr5 = stream_w[5];
   assign stream_addr6 = stream_w[6];
   assign stream_addr7 = stream_w[7];
   assign stream_addr8 = stream_w[8];

   assign LID         = (y_q == Y_MAX);
   assign BOTTOM_WALL = (y_q == '0);
   assign LEFT_WALL   = (x_q == '0) && row_interior;
   assign RIGHT_WALL  = (x_q == X_MAX) && row_interior;

   assign busy       = busy_q;
   assign node_start = (state_q == ST_ISSUE);
   assign sweep_done = (state_q == ST_STEP_END);
   assign all_done   = (state_q == ST_FINISH) || zero_done_q;
   assign buf_sel    = buf_sel_q;
   assign step_count = step_count_q;

endmodule
